tank_level_conditioner: RTL and testbench
=========================================

TANK_LEVEL_CONDITIONER -- requirements
Module: tank_level_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive cycles a synchronized sensor value must differ from its stable value before the stable value changes (legal range 2..255).
REQ-002 Parameter FAULT_CYCLES, default 8: consecutive cycles the implausible code (S=1, I=0) must persist before a fault latches (legal range 1..255).
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port i_raw, input, 1: asynchronous lower-level float switch, 1 = liquid present.
REQ-006 Port s_raw, input, 1: asynchronous upper-level float switch, 1 = liquid present.
REQ-007 Port fault_clr, input, 1: synchronous single-cycle fault acknowledge.
REQ-008 Port i_out, output, 1: conditioned lower-level signal feeding the pump controller's I input.
REQ-009 Port s_out, output, 1: conditioned upper-level signal feeding the pump controller's S input.
REQ-010 Port valid, output, 1: high once the conditioned outputs reflect settled sensor values.
REQ-011 Port fault, output, 1: sensor-plausibility fault, registered.

Function
REQ-012 Each raw input SHALL pass through a two-flip-flop synchronizer; the second stage is the channel's synchronized value.
REQ-013 Each channel SHALL own a stable register and a debounce counter sized to hold DEBOUNCE_CYCLES.
REQ-014 Counter behaviour: synchronized value == stable -> counter cleared; differs -> counter increments; at the edge where the count would reach DEBOUNCE_CYCLES, stable takes the synchronized value and the counter clears.
REQ-015 A raw level change held constant SHALL reach the stable register on the (DEBOUNCE_CYCLES+2)th rising edge, counting the edge that first captures it as the first.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave stable unchanged and SHALL restart the count from zero.
REQ-017 Both channels SHALL debounce independently; simultaneous changes on both are each timed by their own counter.
REQ-018 valid SHALL rise on the (DEBOUNCE_CYCLES+2)th edge after rst deasserts and SHALL stay high until the next reset; while valid=0, i_out=s_out=0.
REQ-019 Without a fault, i_out/s_out SHALL equal the I/S stable registers, with no added register stage.

Reset
REQ-020 While rst=1: synchronizers, stable registers and counters = 0; FSM = OK; i_out=0, s_out=0, valid=0, fault=0.
REQ-021 Asserting rst mid-debounce or mid-fault SHALL abort the operation immediately; no pending change survives reset.

Configuration
REQ-022 Macro LEVEL_PLAUSIBILITY_EN SHALL compile in the plausibility checker.
REQ-023 With the macro defined, a 3-state FSM SHALL run on the stable values:
  OK -> SUSPECT when stable S=1 and stable I=0; fault counter loaded with 1.
  SUSPECT -> OK when the condition clears.
  SUSPECT -> FAULT when the condition persists for FAULT_CYCLES consecutive cycles.
  FAULT is sticky and exits to OK only on fault_clr=1 while the condition is absent.
  fault_clr while the condition is present, or in OK/SUSPECT, SHALL be ignored.
REQ-024 With the macro defined: fault=1 exactly while the FSM is in FAULT; in FAULT, i_out=s_out=0 (safe code); in SUSPECT, outputs track the stable values.
REQ-025 Without the macro: no FSM or fault counter is built; fault is tied to 0; fault_clr is unused.

Verification (DEBOUNCE_CYCLES=4, FAULT_CYCLES=3)
REQ-026 Release rst with i_raw=1, s_raw=0 -> valid=0 and i_out=0 for 5 edges; valid=1 and i_out=1 on the 6th edge.
REQ-027 Steady i_out=1, then i_raw pulses 0 for 3 cycles -> i_out stays 1; fault stays 0.
REQ-028 i_raw and s_raw both rise on the same edge -> i_out and s_out rise together on the 6th edge.
REQ-029 (macro defined) Stable I=0, S=1 held -> fault=1 and i_out=s_out=0 after 3 cycles in SUSPECT. fault_clr pulsed while S=1 -> fault stays 1. S returns to 0 and fault_clr is pulsed -> fault=0 on the next edge.
REQ-030 rst pulsed during SUSPECT and during a debounce count -> all outputs 0 at once; after release the full DEBOUNCE_CYCLES+2 latency applies again.
REQ-031 (macro undefined) Stable I=0, S=1 for 20 cycles -> fault=0, i_out=0, s_out=1 throughout.

Source files
------------

// File: rtl/tank_level_conditioner.sv
// Tank level conditioner: synchronizes and debounces the lower (I) and upper (S)
// float switches for the pump controller, gates the outputs until the sensors
// have settled after reset, and optionally flags the implausible code S=1, I=0.
// Optional feature macro: LEVEL_PLAUSIBILITY_EN builds the plausibility FSM and
// forces the safe code (i_out=s_out=0) while a fault is latched.
module tank_level_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FAULT_CYCLES    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic s_raw,
  input  logic fault_clr,
  output logic i_out,
  output logic s_out,
  output logic valid,
  output logic fault
);

  // Debounce counter holds up to DEBOUNCE_CYCLES; startup counter holds DEBOUNCE_CYCLES+1.
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned VW = $clog2(DEBOUNCE_CYCLES + 2);

  // Channel index 0 = I (lower switch), 1 = S (upper switch).
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    stable;
  logic [DW-1:0] db_cnt [2];
  logic [VW-1:0] start_cnt;
  logic          valid_q;
  logic          force_safe;

  // Two-flop synchronizer per raw switch input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {s_raw, i_raw};
      sync2 <= sync1;
    end
  end

  // Per-channel debounce: stable follows sync2 only after DEBOUNCE_CYCLES
  // consecutive differing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        db_cnt[ch] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        if (sync2[ch] == stable[ch]) begin
          db_cnt[ch] <= '0;
        end else if (db_cnt[ch] == DW'(DEBOUNCE_CYCLES - 1)) begin
          stable[ch] <= sync2[ch];
          db_cnt[ch] <= '0;
        end else begin
          db_cnt[ch] <= db_cnt[ch] + DW'(1);
        end
      end
    end
  end

  // Startup timer: valid rises on the (DEBOUNCE_CYCLES+2)th edge after reset,
  // the first edge at which a level present at release can reach stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_cnt <= '0;
      valid_q   <= 1'b0;
    end else if (!valid_q) begin
      if (start_cnt == VW'(DEBOUNCE_CYCLES + 1)) begin
        valid_q <= 1'b1;
      end else begin
        start_cnt <= start_cnt + VW'(1);
      end
    end
  end

`ifdef LEVEL_PLAUSIBILITY_EN
  localparam int unsigned FW = $clog2(FAULT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_nxt;
  logic          implausible;

  assign implausible = stable[1] & ~stable[0];

  // Plausibility FSM state and persistence counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_OK;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Next state: fcnt counts cycles spent in SUSPECT with the condition present;
  // FAULT is left only by an acknowledge once the sensors look plausible again.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    case (state)
      ST_OK: begin
        if (implausible) begin
          state_nxt = ST_SUSPECT;
          fcnt_nxt  = FW'(1);
        end
      end
      ST_SUSPECT: begin
        if (!implausible) begin
          state_nxt = ST_OK;
          fcnt_nxt  = '0;
        end else if (fcnt >= FW'(FAULT_CYCLES)) begin
          state_nxt = ST_FAULT;
        end else begin
          fcnt_nxt = fcnt + FW'(1);
        end
      end
      ST_FAULT: begin
        if (fault_clr && !implausible) begin
          state_nxt = ST_OK;
          fcnt_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_OK;
        fcnt_nxt  = '0;
      end
    endcase
  end

  // Fault flag decoded straight from the state register.
  always_comb begin
    force_safe = (state == ST_FAULT);
    fault      = force_safe;
  end
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;

  // No plausibility checking: fault never asserts.
  always_comb begin
    force_safe = 1'b0;
    fault      = 1'b0;
  end
`endif

  // Outputs follow the stable registers directly, gated by valid and the safe code.
  always_comb begin
    valid = valid_q;
    i_out = valid_q & stable[0] & ~force_safe;
    s_out = valid_q & stable[1] & ~force_safe;
  end

endmodule

// File: tb/tb_tank_level_conditioner.sv
// Self-checking bench for tank_level_conditioner (DEBOUNCE_CYCLES=4, FAULT_CYCLES=3).
// Expected vectors {i_out, s_out, valid, fault} are queued as stimulus is
// applied and popped for comparison after each rising edge.
module tb_tank_level_conditioner;

  localparam int D = 4;
  localparam int F = 3;

  logic clk = 1'b0;
  logic rst;
  logic i_raw;
  logic s_raw;
  logic fault_clr;
  logic i_out;
  logic s_out;
  logic valid;
  logic fault;

  logic [3:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  tank_level_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .FAULT_CYCLES(F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_raw(i_raw),
    .s_raw(s_raw),
    .fault_clr(fault_clr),
    .i_out(i_out),
    .s_out(s_out),
    .valid(valid),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] got, want;
    for (int n = 0; n < 3; n++) begin
      i_raw = n[0];
      s_raw = ~n[0];
      exp_q.push_back(4'b0000);
      @(posedge clk);
      #1;
      got  = {i_out, s_out, valid, fault};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset[%0d]: got i/s/v/f=%b required %b", n, got, want);
      end
    end
  endtask

  task automatic test_startup();
    logic [3:0] got, want;
    logic       on;
    i_raw = 1'b1;
    s_raw = 1'b0;
    rst   = 1'b0;
    for (int n = 1; n <= D + 2; n++) begin
      on = (n >= D + 2);
      exp_q.push_back({on, 1'b0, on, 1'b0});
      @(posedge clk);
      #1;
      got  = {i_out, s_out, valid, fault};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL startup edge %0d: got i/s/v/f=%b required %b", n, got, want);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] got, want;
    // Two 3-cycle lows separated by one high cycle: the count must restart.
    for (int n = 0; n < 14; n++) begin
      i_raw = !((n <= 2) || (n >= 4 && n <= 6));
      exp_q.push_back(4'b1010);
      @(posedge clk);
      #1;
      got  = {i_out, s_out, valid, fault};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL glitch cycle %0d: got i/s/v/f=%b required %b", n, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, want;
    logic       on;
    i_raw = 1'b0;
    settle(D + 4);
    exp_q.push_back(4'b0010);
    @(posedge clk);
    #1;
    got  = {i_out, s_out, valid, fault};
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL both_low: got i/s/v/f=%b required %b", got, want);
    end
    i_raw = 1'b1;
    s_raw = 1'b1;
    for (int n = 1; n <= D + 3; n++) begin
      on = (n >= D + 2);
      exp_q.push_back({on, on, 1'b1, 1'b0});
      @(posedge clk);
      #1;
      got  = {i_out, s_out, valid, fault};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL simultaneous edge %0d: got i/s/v/f=%b required %b", n, got, want);
      end
    end
  endtask

  task automatic test_plausibility();
    logic [3:0] got, want;
    int         last;
    // Stable I falls on edge D+2 while S stays high.
`ifdef LEVEL_PLAUSIBILITY_EN
    last = D + 2 + F + 2;
`else
    last = D + 2 + 20;
`endif
    i_raw = 1'b0;
    for (int n = 1; n <= last; n++) begin
      if (n < D + 2)
        want = 4'b1110;
`ifdef LEVEL_PLAUSIBILITY_EN
      else if (n < D + 3 + F)
        want = 4'b0110;
      else
        want = 4'b0011;
`else
      else
        want = 4'b0110;
`endif
      exp_q.push_back(want);
      @(posedge clk);
      #1;
      got  = {i_out, s_out, valid, fault};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL implausible edge %0d: got i/s/v/f=%b required %b", n, got, want);
      end
    end
    // Acknowledge while the condition is still present.
    for (int n = 0; n < 2; n++) begin
      fault_clr = (n == 0);
`ifdef LEVEL_PLAUSIBILITY_EN
      exp_q.push_back(4'b0011);
`else
      exp_q.push_back(4'b0110);
`endif
      @(posedge clk);
      #1;
      got  = {i_out, s_out, valid, fault};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL clr_ignored[%0d]: got i/s/v/f=%b required %b", n, got, want);
      end
    end
    fault_clr = 1'b0;
    // Condition clears; fault must persist until acknowledged.
    s_raw = 1'b0;
    for (int n = 1; n <= D + 4; n++) begin
`ifdef LEVEL_PLAUSIBILITY_EN
      want = 4'b0011;
`else
      want = (n < D + 2) ? 4'b0110 : 4'b0010;
`endif
      exp_q.push_back(want);
      @(posedge clk);
      #1;
      got  = {i_out, s_out, valid, fault};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL sticky edge %0d: got i/s/v/f=%b required %b", n, got, want);
      end
    end
    for (int n = 0; n < 2; n++) begin
      fault_clr = (n == 0);
      exp_q.push_back(4'b0010);
      @(posedge clk);
      #1;
      got  = {i_out, s_out, valid, fault};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL clr_accepted[%0d]: got i/s/v/f=%b required %b", n, got, want);
      end
    end
    fault_clr = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [3:0] got, want;
    logic       on;
    i_raw = 1'b1;
    s_raw = 1'b1;
    settle(D + 4);
    // Drop I; one edge after stable I falls the plausibility FSM is in SUSPECT.
    i_raw = 1'b0;
    for (int n = 1; n <= D + 3; n++) begin
      exp_q.push_back((n < D + 2) ? 4'b1110 : 4'b0110);
      @(posedge clk);
      #1;
      got  = {i_out, s_out, valid, fault};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL pre_abort edge %0d: got i/s/v/f=%b required %b", n, got, want);
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      #2;
      rst   = 1'b1;
      i_raw = 1'b1;
      s_raw = 1'b1;
      exp_q.push_back(4'b0000);
      #1;
      got  = {i_out, s_out, valid, fault};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL abort_async[%0d]: got i/s/v/f=%b required %b", pass, got, want);
      end
      settle(2);
      rst = 1'b0;
      for (int n = 1; n <= D + 2; n++) begin
        on = (n >= D + 2);
        exp_q.push_back({on, on, on, 1'b0});
        @(posedge clk);
        #1;
        got  = {i_out, s_out, valid, fault};
        want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL relatency[%0d] edge %0d: got i/s/v/f=%b required %b", pass, n, got, want);
        end
      end
      // Second pass: abort a debounce count that is half way through.
      i_raw = 1'b0;
      settle(D);
    end
  endtask

  initial begin
    rst       = 1'b1;
    i_raw     = 1'b0;
    s_raw     = 1'b0;
    fault_clr = 1'b0;
    settle(2);
    test_reset();
    test_startup();
    test_glitch();
    test_back_to_back();
    test_plausibility();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
